// File: rtl/qbus_tty_tx.sv
// qbus_tty_tx: Q-bus console transmitter slave (TPS status / TPB buffer).
// Decodes CPU bus cycles and answers with RPLY. TPB bytes go into a small FIFO
// and are shifted out as 8N1 serial on txd.
module qbus_tty_tx #(
    parameter logic [15:0] TPS_ADDR  = 16'o177564,
    parameter logic [15:0] TPB_ADDR  = 16'o177566,
    parameter logic [15:0] CLK_DIV   = 16'd35,
    parameter int          FIFO_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ad_n_i,
    output logic [15:0] ad_n_o,
    output logic        ad_oe,
    input  logic        sync_n,
    input  logic        din_n,
    input  logic        dout_n,
    input  logic        wtbt_n,
    input  logic [1:0]  sel_n,
    output logic        rply_n,
    output logic        irq_n,
    output logic        txd
);

    localparam int          DEPTH    = 1 << FIFO_LOG2;
    localparam logic [15:0] DIV_LAST = CLK_DIV - 16'd1;

    typedef enum logic [1:0] {B_IDLE, B_ADDR, B_RD, B_WR} bus_state_e;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

    // Sampled bus inputs
    logic [15:0] ad_s_q;
    logic        sync_s_q, sync_prev_q, din_s_q, dout_s_q, wtbt_s_q;
    logic [1:0]  sel_s_q;

    // Bus slave state
    bus_state_e  bus_q, bus_d;
    logic [15:0] addr_q, addr_d;
    logic        hit_q, hit_d;
    logic [15:0] ad_q, ad_d;
    logic        ad_oe_q, ad_oe_d;
    logic        rply_q, rply_d;
    logic        wr_en;

    // Registers and FIFO
    logic                 ie_q, irq_q;
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_LOG2:0]   wr_ptr_q, rd_ptr_q;
    logic                 empty, full, push_req, push, pop, tps_wr, low_lane, is_tps;
    logic [7:0]           pop_data;
    logic [15:0]          rd_data;
    logic [15:0]          bus_addr;

    // Transmitter state
    tx_state_e   tx_q, tx_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;

    assign bus_addr = ~ad_s_q;
    assign is_tps   = (addr_q[15:1] == TPS_ADDR[15:1]);
    // Only an odd-address byte write misses the low data lane.
    assign low_lane = !(!wtbt_s_q && addr_q[0]);
    assign tps_wr   = wr_en && is_tps && low_lane;
    assign push_req = wr_en && !is_tps && low_lane;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                      (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign pop_data = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
    assign rd_data  = is_tps ? {8'h00, !full, ie_q, 6'b000000} : 16'h0000;

    assign ad_n_o = ad_q;
    assign ad_oe  = ad_oe_q;
    assign rply_n = rply_q;
    assign irq_n  = irq_q;
    assign txd    = txd_q;

    // Single input register stage for all bus pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_s_q      <= '1;
            sync_s_q    <= 1'b1;
            sync_prev_q <= 1'b1;
            din_s_q     <= 1'b1;
            dout_s_q    <= 1'b1;
            wtbt_s_q    <= 1'b1;
            sel_s_q     <= 2'b00;
        end else begin
            // NOTE: non-blocking so every register here captures pre-edge values.
            ad_s_q      <= ad_n_i;
            sync_s_q    <= sync_n;
            sync_prev_q <= sync_s_q;
            din_s_q     <= din_n;
            dout_s_q    <= dout_n;
            wtbt_s_q    <= wtbt_n;
            sel_s_q     <= sel_n;
        end
    end

    // Bus FSM next state and registered bus outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        bus_d   = bus_q;
        addr_d  = addr_q;
        hit_d   = hit_q;
        ad_d    = ad_q;
        ad_oe_d = ad_oe_q;
        rply_d  = rply_q;
        wr_en   = 1'b0;
        case (bus_q)
            B_IDLE: begin
                ad_oe_d = 1'b0;
                rply_d  = 1'b1;
                ad_d    = '1;
                if (sync_prev_q && !sync_s_q) begin
                    addr_d = bus_addr;
                    hit_d  = (sel_s_q == 2'b11) &&
                             ((bus_addr[15:1] == TPS_ADDR[15:1]) ||
                              (bus_addr[15:1] == TPB_ADDR[15:1]));
                    bus_d  = B_ADDR;
                end
            end
            B_ADDR: begin
                if (hit_q && !din_s_q) begin
                    bus_d   = B_RD;
                    ad_d    = ~rd_data;
                    ad_oe_d = 1'b1;
                    rply_d  = 1'b0;
                end else if (hit_q && !dout_s_q) begin
                    bus_d  = B_WR;
                    rply_d = 1'b0;
                    wr_en  = 1'b1;
                end
            end
            B_RD: begin
                if (din_s_q) begin
                    bus_d   = B_ADDR;
                    ad_d    = '1;
                    ad_oe_d = 1'b0;
                    rply_d  = 1'b1;
                end
            end
            B_WR: begin
                if (dout_s_q) begin
                    bus_d  = B_ADDR;
                    rply_d = 1'b1;
                end
            end
            default: bus_d = B_IDLE;
        endcase
        // SYNC released ends the cycle from any state, aborting if needed.
        if (sync_s_q && bus_q != B_IDLE) begin
            bus_d   = B_IDLE;
            ad_d    = '1;
            ad_oe_d = 1'b0;
            rply_d  = 1'b1;
            wr_en   = 1'b0;
        end
    end

    // Bus FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q   <= B_IDLE;
            addr_q  <= '0;
            hit_q   <= 1'b0;
            ad_q    <= '1;
            ad_oe_q <= 1'b0;
            rply_q  <= 1'b1;
        end else begin
            bus_q   <= bus_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            ad_q    <= ad_d;
            ad_oe_q <= ad_oe_d;
            rply_q  <= rply_d;
        end
    end

    // Interrupt enable and registered interrupt request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b1;
        end else begin
            if (tps_wr) ie_q <= !ad_s_q[6];
            irq_q <= !(ie_q && !full);
        end
    end

    // FIFO pointers; one extra bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers alone define valid contents.
        if (push) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= ~ad_s_q[7:0];
    end

    // Transmitter FSM: START, 8 data bits LSB first, STOP, each CLK_DIV clocks.
    always_comb begin
        tx_d    = tx_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (tx_q)
            T_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    tx_d    = T_START;
                    txd_d   = 1'b0;
                    div_d   = '0;
                    shift_d = pop_data;
                end
            end
            T_START: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    tx_d  = T_DATA;
                    bit_d = '0;
                    txd_d = shift_q[0];
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            T_DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d  = T_STOP;
                        txd_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            T_STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        tx_d    = T_START;
                        txd_d   = 1'b0;
                        shift_d = pop_data;
                    end else begin
                        tx_d  = T_IDLE;
                        txd_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: tx_d = T_IDLE;
        endcase
    end

    // Transmitter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= T_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            tx_q    <= tx_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule
